// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the RV32I pipeline: tracks destination tags from EX onward,
// registers EX operand-forward selects, and raises load-use stalls and memory-busy freezes.

module hfc_src_check #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int SEL_W     = 2
) (
  input  logic [REG_AW-1:0]                 src_i,
  input  logic                              use_i,
  input  logic [FWD_DEPTH-1:0]              prod_i,
  input  logic [FWD_DEPTH-1:0][REG_AW-1:0]  rd_i,
  input  logic [LOAD_LAT-1:0]               ld_i,
  output logic [SEL_W-1:0]                  sel_o,
  output logic                              ld_hit_o
);
  // Descending scan so the youngest (lowest) matching slot is the one left in sel_o.
  always_comb begin
    sel_o    = '0;
    ld_hit_o = 1'b0;
    for (int s = FWD_DEPTH-1; s >= 0; s--)
      if (use_i && prod_i[s] && rd_i[s] == src_i) sel_o = SEL_W'(s+1);
    for (int j = 0; j < LOAD_LAT; j++)
      if (use_i && prod_i[j] && ld_i[j] && rd_i[j] == src_i) ld_hit_o = 1'b1;
  end
endmodule

module hazard_forward_ctrl #(
  parameter  int REG_AW    = 5,
  parameter  int FWD_DEPTH = 2,
  parameter  int LOAD_LAT  = 1,
  localparam int SEL_W     = $clog2(FWD_DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              flush_id,
  input  logic              mem_busy,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic              stall_if_id,
  output logic              bubble_ex,
  output logic              freeze_all,
  output logic [31:0]       stall_cnt
);
  typedef enum logic [1:0] {RUN, LDSTALL, MWAIT} state_e;

  // Slots hold valid&we&rd!=0 pre-combined as prod. The oldest stage (FWD_DEPTH) is never
  // searched before the shift, so it is not stored; is_load is only kept where it can stall.
  state_e                              state_q, state_d;
  logic [FWD_DEPTH-1:0]                prod_q, prod_d;
  logic [FWD_DEPTH-1:0][REG_AW-1:0]    rd_q, rd_d;
  logic [LOAD_LAT-1:0]                 ld_q, ld_d;
  logic [SEL_W-1:0]                    fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [31:0]                         cnt_q, cnt_d;

  logic [1:0][REG_AW-1:0] src;
  logic [1:0]             src_use;
  logic [1:0][SEL_W-1:0]  sel;
  logic [1:0]             ld_hit;
  logic                   hazard, kill;

  assign src     = {id_rs2, id_rs1};
  assign src_use = {id_use_rs2, id_use_rs1};

  for (genvar g = 0; g < 2; g++) begin : g_src
    hfc_src_check #(.REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT),
                    .SEL_W(SEL_W)) u_chk (
      .src_i(src[g]), .use_i(src_use[g]), .prod_i(prod_q), .rd_i(rd_q), .ld_i(ld_q),
      .sel_o(sel[g]), .ld_hit_o(ld_hit[g])
    );
  end

  assign hazard = id_valid && (|ld_hit);
  assign kill   = flush_id || hazard;

  always_comb begin
    state_d     = state_q;
    prod_d      = prod_q;
    rd_d        = rd_q;
    ld_d        = ld_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    cnt_d       = cnt_q;
    stall_if_id = 1'b0;
    bubble_ex   = 1'b0;
    freeze_all  = 1'b0;
    if (rst) begin
      state_d = RUN;
    end else if (mem_busy) begin
      state_d     = MWAIT;
      stall_if_id = 1'b1;
      freeze_all  = 1'b1;
    end else begin
      state_d     = (!flush_id && hazard) ? LDSTALL : RUN;
      stall_if_id = !flush_id && hazard;
      bubble_ex   = !flush_id && hazard;
      for (int s = 1; s < FWD_DEPTH; s++) begin
        prod_d[s] = prod_q[s-1];
        rd_d[s]   = rd_q[s-1];
      end
      for (int s = 1; s < LOAD_LAT; s++) ld_d[s] = ld_q[s-1];
      prod_d[0] = !kill && id_valid && id_we && (id_rd != '0);
      rd_d[0]   = id_rd;
      ld_d[0]   = id_is_load;
      fwd_a_d   = kill ? '0 : sel[0];
      fwd_b_d   = kill ? '0 : sel[1];
    end
    if (stall_if_id && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      prod_q  <= '0;
      rd_q    <= '0;
      ld_q    <= '0;
      fwd_a_q <= '0;
      fwd_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      rd_q    <= rd_d;
      ld_q    <= ld_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: default config and FWD_DEPTH=3/LOAD_LAT=2 driven in parallel,
// checked by a stage-list reference model through per-DUT scoreboard queues.

module tb_hazard_forward_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, id_valid = 0, ua = 0, ub = 0, id_we = 0, id_ld = 0, flush_id = 0, mem_busy = 0;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0;

  logic [1:0]  d_fa [2], d_fb [2];
  logic        d_st [2], d_bub [2], d_frz [2];
  logic [31:0] d_cnt [2];

  hazard_forward_ctrl #(.REG_AW(5), .FWD_DEPTH(2), .LOAD_LAT(1)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(rs1), .id_rs2(rs2),
    .id_use_rs1(ua), .id_use_rs2(ub), .id_rd(rd), .id_we(id_we), .id_is_load(id_ld),
    .flush_id(flush_id), .mem_busy(mem_busy), .fwd_a(d_fa[0]), .fwd_b(d_fb[0]),
    .stall_if_id(d_st[0]), .bubble_ex(d_bub[0]), .freeze_all(d_frz[0]), .stall_cnt(d_cnt[0]));

  hazard_forward_ctrl #(.REG_AW(5), .FWD_DEPTH(3), .LOAD_LAT(2)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(rs1), .id_rs2(rs2),
    .id_use_rs1(ua), .id_use_rs2(ub), .id_rd(rd), .id_we(id_we), .id_is_load(id_ld),
    .flush_id(flush_id), .mem_busy(mem_busy), .fwd_a(d_fa[1]), .fwd_b(d_fb[1]),
    .stall_if_id(d_st[1]), .bubble_ex(d_bub[1]), .freeze_all(d_frz[1]), .stall_cnt(d_cnt[1]));

  typedef struct { bit v; bit we; bit ld; logic [4:0] rd; } ins_t;
  typedef struct { bit st; bit bub; bit frz; int fa; int fb; longint cnt; } exp_t;

  int     FD [2] = '{2, 3};
  int     LL [2] = '{1, 2};
  ins_t   pipe [2][8];          // pipe[c][k] = instruction currently in stage EX+k
  int     mfa [2], mfb [2];
  longint mcnt [2];
  exp_t   sbq0 [$], sbq1 [$];
  int     n_chk = 0, n_fail = 0;
  bit     done = 0;

  task automatic cmp(input string nm, input int c, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0d expected %0d", nm, c, $time, act, exp);
    end
  endtask

  function automatic bit is_prod(input int c, input int s, input logic [4:0] src);
    return pipe[c][s].v && pipe[c][s].we && pipe[c][s].rd != 0 && pipe[c][s].rd == src;
  endfunction

  function automatic bit load_use(input int c, input logic [4:0] src, input bit u);
    for (int j = 0; j < LL[c]; j++)
      if (u && is_prod(c, j, src) && pipe[c][j].ld) return 1;
    return 0;
  endfunction

  function automatic int pick(input int c, input logic [4:0] src, input bit u);
    if (!u) return 0;
    for (int s = 0; s < FD[c]; s++)
      if (is_prod(c, s, src)) return s + 1;
    return 0;
  endfunction

  task automatic model(input int c);
    exp_t e; ins_t n; bit haz;
    e = '{st: 0, bub: 0, frz: 0, fa: mfa[c], fb: mfb[c], cnt: mcnt[c]};
    if (rst) begin
      for (int s = 0; s < 8; s++) pipe[c][s] = '{v: 0, we: 0, ld: 0, rd: 0};
      mfa[c] = 0; mfb[c] = 0; mcnt[c] = 0;
    end else if (mem_busy) begin
      e.st = 1; e.frz = 1;
      if (mcnt[c] < 64'hFFFF_FFFF) mcnt[c]++;
    end else begin
      haz   = id_valid && (load_use(c, rs1, ua) || load_use(c, rs2, ub));
      e.st  = haz && !flush_id;
      e.bub = e.st;
      if (flush_id || haz) begin
        n = '{v: 0, we: 0, ld: 0, rd: 0};
        mfa[c] = 0; mfb[c] = 0;
      end else begin
        n = '{v: id_valid, we: id_we, ld: id_ld, rd: rd};
        mfa[c] = pick(c, rs1, ua); mfb[c] = pick(c, rs2, ub);
      end
      for (int s = FD[c]; s >= 1; s--) pipe[c][s] = pipe[c][s-1];
      pipe[c][0] = n;
      if (e.st && mcnt[c] < 64'hFFFF_FFFF) mcnt[c]++;
    end
    if (c == 0) sbq0.push_back(e); else sbq1.push_back(e);
  endtask

  task automatic drive(input bit r, input bit mb, input bit fl, input bit v,
                       input logic [4:0] a, input logic [4:0] b, input bit xa, input bit xb,
                       input logic [4:0] d, input bit we, input bit ld);
    @(posedge clk); #1;
    rst = r; mem_busy = mb; flush_id = fl; id_valid = v; rs1 = a; rs2 = b;
    ua = xa; ub = xb; rd = d; id_we = we; id_ld = ld;
    model(0); model(1);
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle is an output cycle; compare mid-cycle against the queued expectation.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (c == 0 ? sbq0.size() > 0 : sbq1.size() > 0) begin
          e = (c == 0) ? sbq0.pop_front() : sbq1.pop_front();
          cmp("stall_if_id", c, d_st[c],  e.st);
          cmp("bubble_ex",   c, d_bub[c], e.bub);
          cmp("freeze_all",  c, d_frz[c], e.frz);
          cmp("fwd_a",       c, d_fa[c],  e.fa);
          cmp("fwd_b",       c, d_fb[c],  e.fb);
          cmp("stall_cnt",   c, d_cnt[c], e.cnt);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    longint base;
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < 8; s++) pipe[c][s] = '{v: 0, we: 0, ld: 0, rd: 0};
      mfa[c] = 0; mfb[c] = 0; mcnt[c] = 0;
    end
    repeat (2) @(posedge clk);
    drive(1, 1, 1, 1, 5, 5, 1, 1, 5, 1, 1);   // reset dominates busy/flush/hazard inputs
    #1;
    cmp("reset_fwd_a", 0, d_fa[0], 0);
    cmp("reset_cnt",   0, d_cnt[0], 0);
    cmp("reset_frz",   0, d_frz[0], 0);

    // add x5 in EX, then sub reading x5 -> fwd_a=1
    drive(0, 0, 0, 1, 1, 2, 1, 1, 5, 1, 0);
    drive(0, 0, 0, 1, 5, 3, 1, 1, 9, 1, 0);
    cmp("alu_no_stall", 0, d_st[0], 0);
    nop();
    cmp("alu_fwd_a", 0, d_fa[0], 1);
    cmp("alu_fwd_b", 0, d_fb[0], 0);

    // lw x6 then add x7,x6,x6 -> one stall, then WB forward on both
    drive(0, 0, 0, 1, 1, 0, 1, 0, 6, 1, 1);
    drive(0, 0, 0, 1, 6, 6, 1, 1, 7, 1, 0);
    cmp("lu_stall",  0, d_st[0], 1);
    cmp("lu_bubble", 0, d_bub[0], 1);
    drive(0, 0, 0, 1, 6, 6, 1, 1, 7, 1, 0);
    cmp("lu_release", 0, d_st[0], 0);
    nop();
    cmp("lu_fwd_a", 0, d_fa[0], 2);
    cmp("lu_fwd_b", 0, d_fb[0], 2);
    cmp("lu_cnt",   0, d_cnt[0], 1);

    // two producers of x8: youngest wins; then a load to x0 never stalls or forwards
    drive(0, 0, 0, 1, 0, 0, 0, 0, 8, 1, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 8, 1, 0);
    drive(0, 0, 0, 1, 8, 0, 1, 0, 3, 1, 0);
    nop();
    cmp("youngest_fwd_a", 0, d_fa[0], 1);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0, 0, 1, 1, 4, 1, 0);
    cmp("x0_no_stall", 0, d_st[0], 0);
    nop();
    cmp("x0_fwd_a", 0, d_fa[0], 0);

    // load-use killed by flush, then 3 busy cycles
    drive(0, 0, 0, 1, 0, 0, 0, 0, 9, 1, 1);
    drive(0, 0, 1, 1, 9, 9, 1, 1, 2, 1, 0);
    cmp("flush_no_stall", 0, d_st[0], 0);
    nop();
    cmp("flush_fwd_a", 0, d_fa[0], 0);
    base = d_cnt[0];
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 9, 9, 1, 1, 2, 1, 0);
      cmp("busy_freeze", 0, d_frz[0], 1);
    end
    nop();
    cmp("busy_cnt", 0, d_cnt[0], base + 3);

    // deep config: load in EX -> two stalls, then forward from stage 3
    drive(0, 0, 0, 1, 0, 0, 0, 0, 10, 1, 1);
    drive(0, 0, 0, 1, 10, 0, 1, 0, 3, 1, 0);
    cmp("deep_stall1", 1, d_st[1], 1);
    drive(0, 0, 0, 1, 10, 0, 1, 0, 3, 1, 0);
    cmp("deep_stall2", 1, d_st[1], 1);
    drive(0, 0, 0, 1, 10, 0, 1, 0, 3, 1, 0);
    cmp("deep_stall3", 1, d_st[1], 0);
    nop();
    cmp("deep_fwd_a", 1, d_fa[1], 3);

    // reset in the middle of a load-use stall
    drive(0, 0, 0, 1, 0, 0, 0, 0, 11, 1, 1);
    drive(0, 0, 0, 1, 11, 0, 1, 0, 3, 1, 0);
    cmp("pre_rst_stall", 1, d_st[1], 1);
    drive(1, 0, 0, 1, 11, 0, 1, 0, 3, 1, 0);
    cmp("rst_forces_stall0", 1, d_st[1], 0);
    drive(0, 0, 0, 1, 11, 0, 1, 0, 3, 1, 0);
    cmp("post_rst_stall", 1, d_st[1], 0);
    cmp("post_rst_cnt",   1, d_cnt[1], 0);
    cmp("post_rst_fwd_a", 1, d_fa[1], 0);

    // randomized traffic over a small register set so hazards are frequent
    for (int i = 0; i < 2500; i++)
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 7) != 0, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 5)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    done = 1;
    cmp("sb0_drained", 0, sbq0.size(), 0);
    cmp("sb1_drained", 1, sbq1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
